// File: rtl/fifo_monitor_mc_if.sv
// rtl/fifo_monitor_mc_if.sv - strobe/status bundle between FIFO channels and the monitor
interface fifo_monitor_mc_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       wr_en;
  logic [NCH-1:0]       wr_full;
  logic [NCH-1:0]       rd_en;
  logic [NCH-1:0]       rd_empty;
  logic                 clear;
  logic                 clear_busy;
  logic [NCH-1:0]       wr_overflow;
  logic [NCH*CNT_W-1:0] ovf_count;
  logic [NCH-1:0]       rd_underflow;
  logic [NCH*CNT_W-1:0] und_count;
  logic [NCH-1:0]       underflow_wr;
  logic                 irq;

  modport master (
    output wr_en, wr_full, rd_en, rd_empty, clear,
    input  clear_busy, wr_overflow, ovf_count, rd_underflow, und_count, underflow_wr, irq
  );

  modport slave (
    input  wr_en, wr_full, rd_en, rd_empty, clear,
    output clear_busy, wr_overflow, ovf_count, rd_underflow, und_count, underflow_wr, irq
  );
endinterface

// File: rtl/fifo_monitor_mc.sv
// rtl/fifo_monitor_mc.sv - dual-clock FIFO overflow/underflow monitor with toggle-handshake clear
module fifo_monitor_mc #(
  parameter int             NCH         = 4,
  parameter int             CNT_W       = 8,
  parameter int             SYNC_STAGES = 2,
  parameter logic [NCH-1:0] IRQ_MASK    = {NCH{1'b1}}
) (
  input logic              wr_clk,
  input logic              rd_clk,
  input logic              reset,
  fifo_monitor_mc_if.slave mon
);

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  state_t state_q, state_d;
  logic   req_q, req_d;
  logic   clr_accept;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [NCH-1:0]         ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0]       ovf_cnt_q [NCH];
  logic [CNT_W-1:0]       ovf_cnt_d [NCH];
  logic [NCH-1:0]         und_sync_q [SYNC_STAGES];
  logic                   irq_q;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rd_rst;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_seen_q;
  logic                   ack_q;
  logic                   clr_rd;
  logic [NCH-1:0]         und_flag_q, und_flag_d;
  logic [CNT_W-1:0]       und_cnt_q [NCH];
  logic [CNT_W-1:0]       und_cnt_d [NCH];

  // Write-side handshake: a clear is accepted only from IDLE, so clear while busy is dropped
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    clr_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (mon.clear) begin
          clr_accept = 1'b1;
          req_d      = ~req_q;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync_q[SYNC_STAGES-1] == req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_flag_d = ovf_flag_q;
    for (int i = 0; i < NCH; i++) begin
      ovf_cnt_d[i] = ovf_cnt_q[i];
    end
    if (clr_accept) begin
      ovf_flag_d = '0;
      for (int i = 0; i < NCH; i++) begin
        ovf_cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (mon.wr_en[i] && mon.wr_full[i]) begin
          ovf_flag_d[i] = 1'b1;
          if (ovf_cnt_q[i] != '1) begin
            ovf_cnt_d[i] = ovf_cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      ack_sync_q <= '0;
      ovf_flag_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ovf_cnt_q[i] <= '0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) begin
        und_sync_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
      ovf_flag_q <= ovf_flag_d;
      irq_q      <= |((ovf_flag_q | und_sync_q[SYNC_STAGES-1]) & IRQ_MASK);
      for (int i = 0; i < NCH; i++) begin
        ovf_cnt_q[i] <= ovf_cnt_d[i];
      end
      und_sync_q[0] <= und_flag_q;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        und_sync_q[s] <= und_sync_q[s-1];
      end
    end
  end

  // Read domain runs off a synchronised copy of the write-domain reset
  always_ff @(posedge rd_clk) begin
    rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], reset};
  end

  assign rd_rst = rst_sync_q[SYNC_STAGES-1];
  assign clr_rd = req_sync_q[SYNC_STAGES-1] != req_seen_q;

  always_comb begin
    und_flag_d = und_flag_q;
    for (int i = 0; i < NCH; i++) begin
      und_cnt_d[i] = und_cnt_q[i];
    end
    if (clr_rd) begin
      und_flag_d = '0;
      for (int i = 0; i < NCH; i++) begin
        und_cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (mon.rd_en[i] && mon.rd_empty[i]) begin
          und_flag_d[i] = 1'b1;
          if (und_cnt_q[i] != '1) begin
            und_cnt_d[i] = und_cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      req_sync_q <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      und_flag_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        und_cnt_q[i] <= '0;
      end
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      if (clr_rd) begin
        req_seen_q <= req_sync_q[SYNC_STAGES-1];
        ack_q      <= ~ack_q;
      end
      und_flag_q <= und_flag_d;
      for (int i = 0; i < NCH; i++) begin
        und_cnt_q[i] <= und_cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign mon.ovf_count[g*CNT_W +: CNT_W] = ovf_cnt_q[g];
    assign mon.und_count[g*CNT_W +: CNT_W] = und_cnt_q[g];
  end

  assign mon.clear_busy   = (state_q == WAIT_ACK);
  assign mon.wr_overflow  = ovf_flag_q;
  assign mon.rd_underflow = und_flag_q;
  assign mon.underflow_wr = und_sync_q[SYNC_STAGES-1];
  assign mon.irq          = irq_q;

endmodule

// File: tb/tb_fifo_monitor_mc.sv
// tb/tb_fifo_monitor_mc.sv - directed bench for fifo_monitor_mc, rd_clk at 1/3 of wr_clk
module tb_fifo_monitor_mc;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int SS    = 2;
  localparam int BUSY_MAX = 2 * (SS + 1) * 3;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fifo_monitor_mc_if #(.NCH(NCH), .CNT_W(CNT_W)) mon ();

  fifo_monitor_mc #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS)
  ) dut (
    .wr_clk(wr_clk),
    .rd_clk(rd_clk),
    .reset (reset),
    .mon   (mon)
  );

  initial forever #5 wr_clk = ~wr_clk;
  initial begin
    #2;
    forever #15 rd_clk = ~rd_clk;
  end

  task automatic wr_step(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic rd_step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wr_step(15);
    reset = 1'b0;
    wr_step(12);
    checks++; if (mon.wr_overflow !== 4'h0) begin failures++; $display("FAIL reset_wr_overflow got=%h exp=0", mon.wr_overflow); end
    checks++; if (mon.ovf_count !== 16'h0) begin failures++; $display("FAIL reset_ovf_count got=%h exp=0", mon.ovf_count); end
    checks++; if (mon.clear_busy !== 1'b0) begin failures++; $display("FAIL reset_clear_busy got=%b exp=0", mon.clear_busy); end
    checks++; if (mon.underflow_wr !== 4'h0) begin failures++; $display("FAIL reset_underflow_wr got=%h exp=0", mon.underflow_wr); end
    checks++; if (mon.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", mon.irq); end
    checks++; if (mon.rd_underflow !== 4'h0) begin failures++; $display("FAIL reset_rd_underflow got=%h exp=0", mon.rd_underflow); end
    checks++; if (mon.und_count !== 16'h0) begin failures++; $display("FAIL reset_und_count got=%h exp=0", mon.und_count); end
  endtask

  task automatic test_full_no_write;
    mon.wr_full = 4'hF;
    mon.wr_en   = 4'h0;
    wr_step(10);
    mon.wr_full = 4'h0;
    wr_step(2);
    checks++; if (mon.wr_overflow !== 4'h0) begin failures++; $display("FAIL nowrite_wr_overflow got=%h exp=0", mon.wr_overflow); end
    checks++; if (mon.ovf_count !== 16'h0) begin failures++; $display("FAIL nowrite_ovf_count got=%h exp=0", mon.ovf_count); end
    checks++; if (mon.irq !== 1'b0) begin failures++; $display("FAIL nowrite_irq got=%b exp=0", mon.irq); end
  endtask

  task automatic test_underflow;
    int n;
    mon.rd_empty = 4'b0001;
    rd_step(1);
    mon.rd_en = 4'b0011;
    rd_step(1);
    mon.rd_en = 4'b0000;
    checks++; if (mon.rd_underflow !== 4'b0001) begin failures++; $display("FAIL und_first_flag got=%b exp=0001", mon.rd_underflow); end
    n = 0;
    while (mon.underflow_wr[0] !== 1'b1 && n < 10) begin
      wr_step(1);
      n++;
    end
    checks++; if (n < SS || n > SS + 1) begin failures++; $display("FAIL und_wr_latency got=%0d exp=%0d..%0d", n, SS, SS + 1); end
    for (int p = 0; p < 2; p++) begin
      rd_step(1);
      mon.rd_en = 4'b0011;
      rd_step(1);
      mon.rd_en = 4'b0000;
    end
    rd_step(1);
    mon.rd_empty = 4'b0000;
    checks++; if (mon.rd_underflow !== 4'b0001) begin failures++; $display("FAIL und_flags got=%b exp=0001", mon.rd_underflow); end
    checks++; if (mon.und_count !== 16'h0003) begin failures++; $display("FAIL und_count got=%h exp=0003", mon.und_count); end
    wr_step(4);
    checks++; if (mon.underflow_wr !== 4'b0001) begin failures++; $display("FAIL und_wr_flags got=%b exp=0001", mon.underflow_wr); end
    checks++; if (mon.irq !== 1'b1) begin failures++; $display("FAIL und_irq got=%b exp=1", mon.irq); end
  endtask

  task automatic test_overflow_sat;
    mon.wr_full = 4'b0100;
    mon.wr_en   = 4'b0100;
    wr_step(1);
    checks++; if (mon.ovf_count !== 16'h0100) begin failures++; $display("FAIL ovf_first_count got=%h exp=0100", mon.ovf_count); end
    checks++; if (mon.wr_overflow !== 4'b0100) begin failures++; $display("FAIL ovf_first_flag got=%b exp=0100", mon.wr_overflow); end
    wr_step(19);
    mon.wr_full = 4'b0000;
    mon.wr_en   = 4'b0000;
    wr_step(1);
    checks++; if (mon.wr_overflow !== 4'b0100) begin failures++; $display("FAIL ovf_flags got=%b exp=0100", mon.wr_overflow); end
    checks++; if (mon.ovf_count !== 16'h0F00) begin failures++; $display("FAIL ovf_saturate got=%h exp=0F00", mon.ovf_count); end
    checks++; if (mon.irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", mon.irq); end
  endtask

  task automatic test_clear;
    int n;
    mon.clear = 1'b1;
    wr_step(1);
    mon.clear = 1'b0;
    checks++; if (mon.clear_busy !== 1'b1) begin failures++; $display("FAIL clr_busy_rise got=%b exp=1", mon.clear_busy); end
    checks++; if (mon.wr_overflow !== 4'h0) begin failures++; $display("FAIL clr_wr_overflow got=%b exp=0000", mon.wr_overflow); end
    checks++; if (mon.ovf_count !== 16'h0) begin failures++; $display("FAIL clr_ovf_count got=%h exp=0", mon.ovf_count); end
    // clear while busy is ignored, so a simultaneous ch3 overflow must still count
    mon.clear   = 1'b1;
    mon.wr_full = 4'b1000;
    mon.wr_en   = 4'b1000;
    wr_step(1);
    mon.clear   = 1'b0;
    mon.wr_full = 4'b0000;
    mon.wr_en   = 4'b0000;
    n = 2;
    checks++; if (mon.ovf_count !== 16'h1000) begin failures++; $display("FAIL clr_busy_ignored_count got=%h exp=1000", mon.ovf_count); end
    while (mon.clear_busy === 1'b1 && n < 60) begin
      wr_step(1);
      n++;
    end
    checks++; if (mon.clear_busy !== 1'b0 || n > BUSY_MAX) begin failures++; $display("FAIL clr_busy_fall busy=%b cycles=%0d exp=0 within %0d", mon.clear_busy, n, BUSY_MAX); end
    checks++; if (mon.rd_underflow !== 4'h0) begin failures++; $display("FAIL clr_rd_underflow got=%b exp=0000", mon.rd_underflow); end
    checks++; if (mon.und_count !== 16'h0) begin failures++; $display("FAIL clr_und_count got=%h exp=0", mon.und_count); end
    wr_step(4);
    checks++; if (mon.underflow_wr !== 4'h0) begin failures++; $display("FAIL clr_underflow_wr got=%b exp=0000", mon.underflow_wr); end
    wr_step(10);
    checks++; if (mon.clear_busy !== 1'b0) begin failures++; $display("FAIL clr_no_second got=%b exp=0", mon.clear_busy); end
    checks++; if (mon.wr_overflow !== 4'b1000) begin failures++; $display("FAIL clr_ch3_kept got=%b exp=1000", mon.wr_overflow); end
  endtask

  task automatic test_clear_collision;
    int n;
    mon.clear   = 1'b1;
    mon.wr_full = 4'b0010;
    mon.wr_en   = 4'b0010;
    wr_step(1);
    mon.clear   = 1'b0;
    mon.wr_full = 4'b0000;
    mon.wr_en   = 4'b0000;
    checks++; if (mon.wr_overflow !== 4'h0) begin failures++; $display("FAIL coll_wr_overflow got=%b exp=0000", mon.wr_overflow); end
    checks++; if (mon.ovf_count !== 16'h0) begin failures++; $display("FAIL coll_ovf_count got=%h exp=0", mon.ovf_count); end
    n = 1;
    while (mon.clear_busy === 1'b1 && n < 60) begin
      wr_step(1);
      n++;
    end
    checks++; if (mon.clear_busy !== 1'b0 || n > BUSY_MAX) begin failures++; $display("FAIL coll_busy_fall busy=%b cycles=%0d exp=0 within %0d", mon.clear_busy, n, BUSY_MAX); end
    wr_step(5);
    checks++; if (mon.irq !== 1'b0) begin failures++; $display("FAIL coll_irq got=%b exp=0", mon.irq); end
  endtask

  task automatic test_reset_wait_ack;
    int  n;
    logic seen_busy;
    mon.clear = 1'b1;
    wr_step(1);
    mon.clear   = 1'b0;
    mon.wr_full = 4'b0001;
    mon.wr_en   = 4'b0001;
    wr_step(1);
    mon.wr_full = 4'b0000;
    mon.wr_en   = 4'b0000;
    checks++; if (mon.ovf_count !== 16'h0001) begin failures++; $display("FAIL rwa_pre_count got=%h exp=0001", mon.ovf_count); end
    reset = 1'b1;
    wr_step(1);
    checks++; if (mon.clear_busy !== 1'b0) begin failures++; $display("FAIL rwa_busy got=%b exp=0", mon.clear_busy); end
    checks++; if (mon.ovf_count !== 16'h0) begin failures++; $display("FAIL rwa_ovf_count got=%h exp=0", mon.ovf_count); end
    checks++; if (mon.wr_overflow !== 4'h0) begin failures++; $display("FAIL rwa_wr_overflow got=%b exp=0000", mon.wr_overflow); end
    wr_step(14);
    reset = 1'b0;
    wr_step(12);
    checks++; if (mon.und_count !== 16'h0) begin failures++; $display("FAIL rwa_und_count got=%h exp=0", mon.und_count); end
    mon.rd_empty = 4'b0010;
    rd_step(1);
    mon.rd_en = 4'b0010;
    rd_step(1);
    mon.rd_en    = 4'b0000;
    mon.rd_empty = 4'b0000;
    rd_step(6);
    checks++; if (mon.und_count !== 16'h0010) begin failures++; $display("FAIL rwa_no_spurious got=%h exp=0010", mon.und_count); end
    checks++; if (mon.clear_busy !== 1'b0) begin failures++; $display("FAIL rwa_idle_busy got=%b exp=0", mon.clear_busy); end
    wr_step(1);
    mon.clear = 1'b1;
    wr_step(1);
    mon.clear = 1'b0;
    seen_busy = mon.clear_busy;
    n = 1;
    while (mon.clear_busy === 1'b1 && n < 60) begin
      wr_step(1);
      n++;
    end
    checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL rwa_busy_pulse got=%b exp=1", seen_busy); end
    checks++; if (mon.clear_busy !== 1'b0 || n > BUSY_MAX) begin failures++; $display("FAIL rwa_busy_fall busy=%b cycles=%0d exp=0 within %0d", mon.clear_busy, n, BUSY_MAX); end
    checks++; if (mon.und_count !== 16'h0) begin failures++; $display("FAIL rwa_final_und got=%h exp=0", mon.und_count); end
  endtask

  initial begin
    mon.wr_en    = '0;
    mon.wr_full  = '0;
    mon.rd_en    = '0;
    mon.rd_empty = '0;
    mon.clear    = 1'b0;
    test_reset;
    test_full_no_write;
    test_underflow;
    test_overflow_sat;
    test_clear;
    test_clear_collision;
    test_reset_wait_ack;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
